alu_result_capture: RTL
=======================

Name: alu_result_capture

Overview:
- Registered stage directly downstream of the 64-bit ripple adder in the ARM ALU datapath.
- Waits a programmable number of clock cycles for the gate-delayed ripple chain to settle.
- Then captures the sum, carry-out and overflow, and computes the NZCV condition flags.
- Presents the result to the consumer (register-file writeback) under a valid/ready handshake.

Parameters:
- WIDTH, 64, datapath width. Must match the adder.
- SETTLE_CYCLES, 4, cycles waited after start before capture. Legal range 1..255.
- CNT_W, $clog2(SETTLE_CYCLES+1), settle counter width. Derived; not overridden.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  upstream request: adder operands are applied and held stable
- in_ready  output  1  block can accept start; high only in IDLE
- set_flags  input  1  sampled with accepted start; 1 = update NZCV (ADDS/SUBS), 0 = result only
- sum_in  input  WIDTH  adder result bus
- cout_in  input  1  adder carry-out
- overflow_in  input  1  adder signed overflow
- result_out  output  WIDTH  captured result
- out_valid  output  1  result_out and flags valid
- out_ready  input  1  consumer accepts the result
- flag_n, flag_z, flag_c, flag_v  output  1 each  architectural condition flags
- busy  output  1  high in SETTLE or HOLD

Behaviour:
- Reset values: state=IDLE, result_out=0, all flags=0, out_valid=0, busy=0, in_ready=1, counter=0, latched set_flags=0.
- States: IDLE, SETTLE, HOLD.
- IDLE:
  - in_ready=1.
  - If start=1: latch set_flags, load counter with SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - in_ready=0; start is ignored.
  - Counter decrements once per cycle.
  - In the cycle the counter is 0: sample sum_in, cout_in and overflow_in into result_out, then go to HOLD.
  - If latched set_flags=1, also update: N=sum_in[WIDTH-1]; Z=(sum_in==0); C=cout_in; V=overflow_in.
  - If latched set_flags=0, flags keep their previous values.
- HOLD:
  - out_valid=1.
  - result_out and flags are stable until the handshake (out_valid & out_ready), then go to IDLE.
  - out_valid drops the cycle after the handshake.
- Latency: start accepted in cycle t gives out_valid=1 in cycle t+SETTLE_CYCLES+1.
  - Back-to-back throughput: one result per SETTLE_CYCLES+2 cycles when out_ready is tied high.
- Operands must stay stable from start until capture. This is upstream's obligation and is not checked.
- result_out and flags persist after the handshake until the next capture.
- A start pulse in SETTLE or HOLD is dropped. Upstream must honour in_ready.
- out_ready while not in HOLD has no effect.
- Reset mid-operation (SETTLE or HOLD): discard the in-flight result, restore all reset values, go to IDLE next cycle.
- Z is computed over the full WIDTH bits.

Optional Feature:
- Macro: ALU_STICKY_OVERFLOW_EN.
- Defined:
  - Adds input clear_sticky (1) and output flag_q (1).
  - flag_q is set on any capture with overflow_in=1, regardless of set_flags.
  - flag_q is cleared when clear_sticky=1.
  - Simultaneous set and clear: set wins.
  - Reset value of flag_q is 0.
- Undefined: both ports and all related logic are absent. Base behaviour is unchanged.

Decomposition:
- Package alu_pkg holds:
  - the capture_state_t enum {IDLE, SETTLE, HOLD};
  - an nzcv_t packed struct {n, z, c, v};
  - the ALU_WIDTH=64 constant.
- Sub-module alu_flag_compute:
  - combinational; inputs sum_in, cout_in, overflow_in; output nzcv_t.
  - Reused by the future logic-unit flag path.

Test Plan:
- Basic ADDS: reset, then start with set_flags=1, sum_in=64'h0000_0000_0000_0005, cout=0, ovf=0, out_ready=1 → out_valid at start+5 cycles (SETTLE_CYCLES=4), result_out=5, NZCV=0000.
- Zero/carry: sum_in=0, cout_in=1, set_flags=1 → Z=1, C=1, N=0, V=0.
- Overflow/negative: sum_in=64'h8000_0000_0000_0000, ovf=1 → N=1, V=1. A following start with set_flags=0 and sum_in=1 → result_out=1, flags remain N=1, V=1.
- Backpressure: out_ready=0 for 10 cycles in HOLD → out_valid, result_out and flags stable, in_ready=0, extra start ignored. Raise out_ready → one handshake, IDLE next cycle.
- Reset mid-SETTLE: assert reset with counter=2 → next cycle IDLE, out_valid=0, flags=0, no capture follows.
- ALU_STICKY_OVERFLOW_EN:
  - capture with ovf=1, then ovf=0 → flag_q stays 1;
  - clear_sticky pulse alone → flag_q=0;
  - clear_sticky coincident with an ovf=1 capture → flag_q=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result-capture datapath.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } capture_state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

endpackage

// File: rtl/alu_flag_compute.sv
// Combinational NZCV derivation from an adder result; also intended for the logic-unit flag path.
module alu_flag_compute
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] sum_in,
    input  logic             cout_in,
    input  logic             overflow_in,
    output nzcv_t            nzcv
);

    // Z covers the full datapath width.
    always_comb begin
        nzcv.n = sum_in[WIDTH-1];
        nzcv.z = (sum_in == '0);
        nzcv.c = cout_in;
        nzcv.v = overflow_in;
    end

endmodule

// File: rtl/alu_result_capture.sv
// Registered capture stage after the ripple adder: waits SETTLE_CYCLES for the carry chain,
// captures sum and NZCV, then holds the result under a valid/ready handshake.
// Optional feature: define ALU_STICKY_OVERFLOW_EN to add a sticky overflow flag (flag_q)
// with its clear_sticky input.
module alu_result_capture
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH         = ALU_WIDTH,
    parameter int unsigned SETTLE_CYCLES = 4,
    localparam int unsigned CNT_W        = $clog2(SETTLE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             in_ready,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             cout_in,
    input  logic             overflow_in,
    output logic [WIDTH-1:0] result_out,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef ALU_STICKY_OVERFLOW_EN
    input  logic             clear_sticky,
    output logic             flag_q,
`endif
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(SETTLE_CYCLES - 1);

    capture_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             set_flags_q;
    logic [WIDTH-1:0] result_q;
    nzcv_t            nzcv_q;
    nzcv_t            nzcv_new;
    logic             accept;
    logic             capture;

    alu_flag_compute #(
        .WIDTH (WIDTH)
    ) u_flag_compute (
        .sum_in      (sum_in),
        .cout_in     (cout_in),
        .overflow_in (overflow_in),
        .nzcv        (nzcv_new)
    );

    assign accept  = (state_q == IDLE) && start;
    assign capture = (state_q == SETTLE) && (cnt_q == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start outside IDLE and out_ready outside HOLD are ignored.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)       state_d = SETTLE;
            SETTLE:  if (cnt_q == '0) state_d = HOLD;
            HOLD:    if (out_ready)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == HOLD);
        busy      = (state_q == SETTLE) || (state_q == HOLD);
    end

    // Settle counter and set_flags latch, loaded on an accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            set_flags_q <= 1'b0;
        end else if (accept) begin
            cnt_q       <= CntLoad;
            set_flags_q <= set_flags;
        end else if ((state_q == SETTLE) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Result and flag capture; values persist past the handshake until the next capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            nzcv_q   <= '0;
        end else if (capture) begin
            result_q <= sum_in;
            if (set_flags_q) begin
                nzcv_q <= nzcv_new;
            end
        end
    end

    assign result_out = result_q;
    assign flag_n     = nzcv_q.n;
    assign flag_z     = nzcv_q.z;
    assign flag_c     = nzcv_q.c;
    assign flag_v     = nzcv_q.v;

`ifdef ALU_STICKY_OVERFLOW_EN
    logic sticky_q;

    // Sticky overflow: any overflowing capture sets it, set beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else if (capture && overflow_in) begin
            sticky_q <= 1'b1;
        end else if (clear_sticky) begin
            sticky_q <= 1'b0;
        end
    end

    assign flag_q = sticky_q;
`endif

endmodule
